tcdm_bank_array_ctrl: RTL
=========================

Name: tcdm_bank_array_ctrl

Overview:
- Parametrised multi-bank TCDM memory array with per-bank request/grant handshake and configurable read latency.
- Adds a built-in zero-initialisation sweep engine and a power-down gate.
- Sits between the cluster TCDM interconnect and the physical SRAM banks.
- Successor to the fixed 32-bit, latency-1, always-granting bank wrapper.

Parameters:
- NB_BANKS, 16, number of independent banks
- BANK_SIZE, 1024, words per bank, power of two, min 4
- DATA_WIDTH, 32, word width in bits, multiple of 8
- ADDR_WIDTH, 32, per-bank request address width; only the low $clog2(BANK_SIZE) bits are used
- LATENCY, 1, read latency in cycles from grant to rvalid, range 1..4

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- init_req_i  in  1  single-cycle pulse: start a zero-fill sweep of all banks
- pwdn_i  in  1  power-down request, level sensitive
- req_i  in  NB_BANKS  per-bank request
- wen_i  in  NB_BANKS  per-bank write enable, active low (0 = write, 1 = read)
- add_i  in  NB_BANKS*ADDR_WIDTH  per-bank word address
- wdata_i  in  NB_BANKS*DATA_WIDTH  write data
- be_i  in  NB_BANKS*DATA_WIDTH/8  byte enables, 1 = byte written
- gnt_o  out  NB_BANKS  combinational grant
- rvalid_o  out  NB_BANKS  read response valid
- rdata_o  out  NB_BANKS*DATA_WIDTH  read data
- init_busy_o  out  1  zero-fill sweep in progress
- init_done_o  out  1  sticky: sweep completed since last reset or power-down

Behaviour:
- Reset (async, rst_i=1):
  - FSM returns to IDLE; sweep counter = 0.
  - rvalid_o, rdata_o, init_busy_o and init_done_o all = 0; latency pipeline flushed.
  - Memory contents are not reset.
- FSM states:
  - IDLE: normal operation. gnt_o[i] = req_i[i].
  - INIT: gnt_o = 0. Counter c writes all-zero, all bytes, to address c of every bank each cycle. c increments 0..BANK_SIZE-1. After the write at BANK_SIZE-1: c wraps to 0, init_done_o is set, go to IDLE. A full sweep takes exactly BANK_SIZE cycles. init_busy_o = 1 throughout INIT.
  - PWDN: gnt_o = 0, no memory access; contents retained (simulation model).
- Transitions:
  - IDLE -> INIT on init_req_i=1.
  - Any state -> PWDN on pwdn_i=1; pwdn has priority over init_req_i.
  - PWDN -> IDLE on pwdn_i=0.
- Entering PWDN from INIT aborts the sweep: counter cleared, init_done_o cleared, no resume.
- Entering PWDN from any state clears init_done_o.
- init_req_i while in INIT or PWDN is ignored.
- Accepted transfer = req_i[i] & gnt_o[i].
- Writes:
  - Update only bytes whose be_i bit is set, at the rising edge of the accept cycle.
  - Writes produce no rvalid.
- Reads:
  - rvalid_o[i] = 1 exactly LATENCY cycles after the accept cycle, for one cycle.
  - rdata_o[i] holds the word from the accept-cycle address, registered through LATENCY-1 stages after the 1-cycle array read.
  - rdata_o holds its last value when rvalid_o = 0.
- Fully pipelined: one accepted request per bank per cycle, back-to-back, independent per bank.
- Same-bank write then read of the same address on the next cycle returns the new data. No same-cycle read-during-write: a single port per bank.
- Address bits above $clog2(BANK_SIZE) are ignored, so addresses alias modulo BANK_SIZE.
- Responses already in the latency pipeline when INIT or PWDN is entered still complete with their rvalid.
- A reset mid-sweep leaves the memory partially zeroed; init_done_o = 0.

Test Plan:
- LATENCY=2, bank 3: write 0xDEADBEEF to addr 5 with be=0xF, then read addr 5 -> gnt same cycle, rvalid_o[3] two cycles after read accept, rdata=0xDEADBEEF.
- Partial write: addr 7 holds 0x11223344; write 0xAABBCCDD with be=0b0101 -> subsequent read returns 0x11BB33DD.
- BANK_SIZE=16: fill all banks with 0xFFFFFFFF, pulse init_req_i -> init_busy_o high exactly 16 cycles, gnt_o=0 with req_i held, then init_done_o=1 and every address reads 0x00000000.
- Assert pwdn_i at sweep cycle 8 of 16 -> init_busy_o=0, init_done_o=0, addrs 0..7 read 0, addrs 8..15 keep 0xFFFFFFFF after pwdn_i drops; re-init completes normally.
- Back-to-back reads of addrs 0,1,2 on all banks with LATENCY=3 -> three consecutive rvalid pulses per bank in order. Address 0x10+2 with BANK_SIZE=16 aliases to addr 2.
- Assert rst_i mid-sweep and with reads in flight -> all outputs 0 asynchronously, no rvalid after release, FSM in IDLE, gnt_o follows req_i.

Source files
------------

// File: rtl/tcdm_bank_array_ctrl.sv
// Multi-bank TCDM array: per-bank req/gnt with configurable read latency,
// a zero-fill sweep engine and a power-down gate in front of the SRAM banks.
module tcdm_bank_array_ctrl #(
    parameter int NB_BANKS   = 16,
    parameter int BANK_SIZE  = 1024,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int LATENCY    = 1
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             init_req_i,
    input  logic                             pwdn_i,
    input  logic [NB_BANKS-1:0]              req_i,
    input  logic [NB_BANKS-1:0]              wen_i,
    input  logic [NB_BANKS*ADDR_WIDTH-1:0]   add_i,
    input  logic [NB_BANKS*DATA_WIDTH-1:0]   wdata_i,
    input  logic [NB_BANKS*DATA_WIDTH/8-1:0] be_i,
    output logic [NB_BANKS-1:0]              gnt_o,
    output logic [NB_BANKS-1:0]              rvalid_o,
    output logic [NB_BANKS*DATA_WIDTH-1:0]   rdata_o,
    output logic                             init_busy_o,
    output logic                             init_done_o
);

    localparam int IDX_W = $clog2(BANK_SIZE);
    localparam int NBE   = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        PWDN
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] sweep_cnt;
    logic             init_busy;
    logic             init_done;
    logic             sweep_we;
    logic             unused_addr_bits;

    // Power-down wins over everything and aborts any sweep without resuming it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            sweep_cnt <= '0;
            init_busy <= 1'b0;
            init_done <= 1'b0;
        end else if (pwdn_i) begin
            state     <= PWDN;
            sweep_cnt <= '0;
            init_busy <= 1'b0;
            init_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (init_req_i) begin
                        state     <= INIT;
                        init_busy <= 1'b1;
                    end
                end
                INIT: begin
                    if (sweep_cnt == IDX_W'(BANK_SIZE - 1)) begin
                        sweep_cnt <= '0;
                        state     <= IDLE;
                        init_busy <= 1'b0;
                        init_done <= 1'b1;
                    end else begin
                        sweep_cnt <= sweep_cnt + 1'b1;
                    end
                end
                PWDN:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign gnt_o            = (state == IDLE) ? req_i : '0;
    assign sweep_we         = (state == INIT) && !pwdn_i;
    assign init_busy_o      = init_busy;
    assign init_done_o      = init_done;
    assign unused_addr_bits = ^add_i;

    for (genvar b = 0; b < NB_BANKS; b++) begin : g_bank
        logic [DATA_WIDTH-1:0] mem [BANK_SIZE];
        logic [IDX_W-1:0]      addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic [NBE-1:0]        be;
        logic                  acc_wr;
        logic                  acc_rd;
        logic [LATENCY-1:0]    vld;
        logic [DATA_WIDTH-1:0] dat [LATENCY];

        assign addr   = add_i[b*ADDR_WIDTH +: IDX_W];
        assign wdata  = wdata_i[b*DATA_WIDTH +: DATA_WIDTH];
        assign be     = be_i[b*NBE +: NBE];
        assign acc_wr = req_i[b] && gnt_o[b] && !wen_i[b];
        assign acc_rd = req_i[b] && gnt_o[b] && wen_i[b];

        // Storage is deliberately not reset; only the sweep clears it.
        always_ff @(posedge clk_i) begin
            if (sweep_we) begin
                mem[sweep_cnt] <= '0;
            end else if (acc_wr) begin
                for (int k = 0; k < NBE; k++) begin
                    if (be[k]) begin
                        mem[addr][k*8 +: 8] <= wdata[k*8 +: 8];
                    end
                end
            end
        end

        // Stage 0 is the array read; later stages only load on valid so data holds.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                vld <= '0;
                for (int s = 0; s < LATENCY; s++) begin
                    dat[s] <= '0;
                end
            end else begin
                vld[0] <= acc_rd;
                if (acc_rd) begin
                    dat[0] <= mem[addr];
                end
                for (int s = 1; s < LATENCY; s++) begin
                    vld[s] <= vld[s-1];
                    if (vld[s-1]) begin
                        dat[s] <= dat[s-1];
                    end
                end
            end
        end

        assign rvalid_o[b]                           = vld[LATENCY-1];
        assign rdata_o[b*DATA_WIDTH +: DATA_WIDTH]   = dat[LATENCY-1];
    end

endmodule
